// File: rtl/dsp_aw_channel_pkg.sv
// Shared definitions for the write-address dispatcher.
// - Default bus field widths and the packed AW payload layout.
// - Slave-select decode helper that clamps out-of-range indices.
package dsp_aw_channel_pkg;

    localparam int SLV_AMT_DEF           = 2;
    localparam int ADDR_WIDTH_DEF        = 32;
    localparam int TRANS_MST_ID_W_DEF    = 5;
    localparam int TRANS_BURST_W_DEF     = 2;
    localparam int TRANS_DATA_LEN_W_DEF  = 3;
    localparam int TRANS_DATA_SIZE_W_DEF = 3;

    localparam int AW_PAYLOAD_W = TRANS_MST_ID_W_DEF + ADDR_WIDTH_DEF + TRANS_BURST_W_DEF
                                + TRANS_DATA_LEN_W_DEF + TRANS_DATA_SIZE_W_DEF;

    // Field order matches the concatenation used on the slave-side outputs.
    typedef struct packed {
        logic [TRANS_MST_ID_W_DEF-1:0]    id;
        logic [ADDR_WIDTH_DEF-1:0]        addr;
        logic [TRANS_BURST_W_DEF-1:0]     burst;
        logic [TRANS_DATA_LEN_W_DEF-1:0]  len;
        logic [TRANS_DATA_SIZE_W_DEF-1:0] size;
    } aw_payload_t;

    // Address field values past the last slave are routed to the last slave.
    function automatic int slv_decode(input int field, input int slv_amt);
        if (field >= slv_amt) begin
            return slv_amt - 1;
        end else begin
            return field;
        end
    endfunction

endpackage

// File: rtl/axi_skid_buffer.sv
// Two-entry skid buffer with valid/ready on both sides.
// - in_ready_o is driven purely from the skid-entry flop, so the upstream
//   ready never depends combinationally on out_ready_i.
// - Entries leave in arrival order; full rate when downstream is ready.
// Ports: clk, rst_n (synchronous, active-low), in_valid_i/in_ready_o/in_data_i,
//        out_valid_o/out_ready_i/out_data_o.
module axi_skid_buffer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o
);

    logic                  main_valid_q, main_valid_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic                  push_s;
    logic                  pop_s;

    assign in_ready_o  = ~skid_valid_q;
    assign out_valid_o = main_valid_q;
    assign out_data_o  = main_data_q;

    // Next-state for the main/skid entries from the push and pop strobes.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        push_s       = in_valid_i & ~skid_valid_q;
        pop_s        = main_valid_q & out_ready_i;
        if (pop_s) begin
            if (skid_valid_q) begin
                // push cannot happen here: in_ready_o is low while skid is valid
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (push_s) begin
                main_data_d  = in_data_i;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (push_s) begin
            if (main_valid_q) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data_i;
            end else begin
                main_valid_d = 1'b1;
                main_data_d  = in_data_i;
            end
        end else begin
            main_valid_d = main_valid_q;
        end
    end

    // Entry registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/dsp_aw_channel.sv
// Write-address dispatcher.
// - Buffers master AW transfers in a two-entry skid buffer, decodes the target
//   slave from the buffered AWADDR and raises that slave's AWVALID.
// - Each slave-side handshake pulses dsp_AW_shift_en_o with the slave index so
//   the B-order and W-order FIFOs record the routing.
// - New AWs are held back while the B-order FIFO is at the outstanding limit or
//   the W-order FIFO is full; a VALID already raised is held until accepted.
// Ports: ACLK_i/ARESETn_i (sync active-low), m_AW* master side, sa_AW* slave
//        side (payload shared, VALID one-hot), sa_B_outst_ctn_i, dsp_W_full_i,
//        dsp_AW_slv_id_o, dsp_AW_shift_en_o.
module dsp_aw_channel
    import dsp_aw_channel_pkg::*;
#(
    parameter int SLV_AMT           = SLV_AMT_DEF,
    parameter int OUTSTANDING_AMT   = 8,
    parameter int OUTST_CTN_W       = $clog2(OUTSTANDING_AMT) + 1,
    parameter int ADDR_WIDTH        = ADDR_WIDTH_DEF,
    parameter int TRANS_MST_ID_W    = TRANS_MST_ID_W_DEF,
    parameter int TRANS_BURST_W     = TRANS_BURST_W_DEF,
    parameter int TRANS_DATA_LEN_W  = TRANS_DATA_LEN_W_DEF,
    parameter int TRANS_DATA_SIZE_W = TRANS_DATA_SIZE_W_DEF,
    parameter int SLV_ID_W          = $clog2(SLV_AMT),
    parameter int SLV_ID_MSB_IDX    = 30,
    parameter int SLV_ID_LSB_IDX    = 30
) (
    input  logic                         ACLK_i,
    input  logic                         ARESETn_i,
    input  logic [TRANS_MST_ID_W-1:0]    m_AWID_i,
    input  logic [ADDR_WIDTH-1:0]        m_AWADDR_i,
    input  logic [TRANS_BURST_W-1:0]     m_AWBURST_i,
    input  logic [TRANS_DATA_LEN_W-1:0]  m_AWLEN_i,
    input  logic [TRANS_DATA_SIZE_W-1:0] m_AWSIZE_i,
    input  logic                         m_AWVALID_i,
    output logic                         m_AWREADY_o,
    output logic [TRANS_MST_ID_W-1:0]    sa_AWID_o,
    output logic [ADDR_WIDTH-1:0]        sa_AWADDR_o,
    output logic [TRANS_BURST_W-1:0]     sa_AWBURST_o,
    output logic [TRANS_DATA_LEN_W-1:0]  sa_AWLEN_o,
    output logic [TRANS_DATA_SIZE_W-1:0] sa_AWSIZE_o,
    output logic [SLV_AMT-1:0]           sa_AWVALID_o,
    input  logic [SLV_AMT-1:0]           sa_AWREADY_i,
    input  logic [OUTST_CTN_W-1:0]       sa_B_outst_ctn_i,
    input  logic                         dsp_W_full_i,
    output logic [SLV_ID_W-1:0]          dsp_AW_slv_id_o,
    output logic                         dsp_AW_shift_en_o
);

    localparam int PAYLOAD_W = TRANS_MST_ID_W + ADDR_WIDTH + TRANS_BURST_W
                             + TRANS_DATA_LEN_W + TRANS_DATA_SIZE_W;
    localparam int FIELD_W   = SLV_ID_MSB_IDX - SLV_ID_LSB_IDX + 1;

    logic [PAYLOAD_W-1:0] in_data_s;
    logic [PAYLOAD_W-1:0] out_data_s;
    logic                 main_valid_s;
    logic [FIELD_W-1:0]   field_s;
    logic [SLV_ID_W-1:0]  slv_id_s;
    logic                 stall_s;
    logic                 offer_s;
    logic                 handshake_s;
    logic [SLV_AMT-1:0]   sa_valid_s;
    logic                 valid_hold_q, valid_hold_d;

    assign in_data_s = {m_AWID_i, m_AWADDR_i, m_AWBURST_i, m_AWLEN_i, m_AWSIZE_i};

    axi_skid_buffer #(
        .DATA_WIDTH (PAYLOAD_W)
    ) u_skid (
        .clk         (ACLK_i),
        .rst_n       (ARESETn_i),
        .in_valid_i  (m_AWVALID_i),
        .in_ready_o  (m_AWREADY_o),
        .in_data_i   (in_data_s),
        .out_valid_o (main_valid_s),
        .out_ready_i (handshake_s),
        .out_data_o  (out_data_s)
    );

    assign {sa_AWID_o, sa_AWADDR_o, sa_AWBURST_o, sa_AWLEN_o, sa_AWSIZE_o} = out_data_s;

    // Decode, stall gating, VALID hold and one-hot slave VALID.
    always_comb begin
        field_s  = sa_AWADDR_o[SLV_ID_MSB_IDX:SLV_ID_LSB_IDX];
        slv_id_s = SLV_ID_W'(slv_decode(int'(field_s), SLV_AMT));
        stall_s  = (sa_B_outst_ctn_i == OUTST_CTN_W'(OUTSTANDING_AMT)) | dsp_W_full_i;
        // Stall only blocks a rising VALID; reset suppresses everything so no
        // push strobe escapes in a reset cycle.
        offer_s      = ARESETn_i & main_valid_s & (~stall_s | valid_hold_q);
        handshake_s  = offer_s & sa_AWREADY_i[slv_id_s];
        valid_hold_d = offer_s & ~handshake_s;
        sa_valid_s   = '0;
        for (int i = 0; i < SLV_AMT; i++) begin
            if (offer_s && (int'(slv_id_s) == i)) begin
                sa_valid_s[i] = 1'b1;
            end else begin
                sa_valid_s[i] = 1'b0;
            end
        end
    end

    assign sa_AWVALID_o      = sa_valid_s;
    assign dsp_AW_shift_en_o = handshake_s;
    assign dsp_AW_slv_id_o   = slv_id_s;

    // Remembers that VALID was offered but not yet accepted.
    always_ff @(posedge ACLK_i) begin
        if (!ARESETn_i) begin
            valid_hold_q <= 1'b0;
        end else begin
            valid_hold_q <= valid_hold_d;
        end
    end

endmodule

// File: tb/tb_dsp_aw_channel.sv
module tb_dsp_aw_channel;
    import dsp_aw_channel_pkg::*;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [4:0]  m_AWID_i;
    logic [31:0] m_AWADDR_i;
    logic [1:0]  m_AWBURST_i;
    logic [2:0]  m_AWLEN_i;
    logic [2:0]  m_AWSIZE_i;
    logic        m_AWVALID_i;
    logic        m_AWREADY_o;
    logic [4:0]  sa_AWID_o;
    logic [31:0] sa_AWADDR_o;
    logic [1:0]  sa_AWBURST_o;
    logic [2:0]  sa_AWLEN_o;
    logic [2:0]  sa_AWSIZE_o;
    logic [1:0]  sa_AWVALID_o;
    logic [1:0]  sa_AWREADY_i;
    logic [3:0]  sa_B_outst_ctn_i;
    logic        dsp_W_full_i;
    logic        dsp_AW_slv_id_o;
    logic        dsp_AW_shift_en_o;

    int n_pass = 0;
    int n_total = 0;

    always #5 aclk = ~aclk;

    dsp_aw_channel dut (
        .ACLK_i            (aclk),
        .ARESETn_i         (aresetn),
        .m_AWID_i          (m_AWID_i),
        .m_AWADDR_i        (m_AWADDR_i),
        .m_AWBURST_i       (m_AWBURST_i),
        .m_AWLEN_i         (m_AWLEN_i),
        .m_AWSIZE_i        (m_AWSIZE_i),
        .m_AWVALID_i       (m_AWVALID_i),
        .m_AWREADY_o       (m_AWREADY_o),
        .sa_AWID_o         (sa_AWID_o),
        .sa_AWADDR_o       (sa_AWADDR_o),
        .sa_AWBURST_o      (sa_AWBURST_o),
        .sa_AWLEN_o        (sa_AWLEN_o),
        .sa_AWSIZE_o       (sa_AWSIZE_o),
        .sa_AWVALID_o      (sa_AWVALID_o),
        .sa_AWREADY_i      (sa_AWREADY_i),
        .sa_B_outst_ctn_i  (sa_B_outst_ctn_i),
        .dsp_W_full_i      (dsp_W_full_i),
        .dsp_AW_slv_id_o   (dsp_AW_slv_id_o),
        .dsp_AW_shift_en_o (dsp_AW_shift_en_o)
    );

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  exp_valid;
        logic        exp_slv;
    } route_vec_t;

    route_vec_t  rv [6];
    aw_payload_t mq [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic smp();
        @(negedge aclk);
    endtask

    task automatic set_aw(input logic [4:0] id, input logic [31:0] addr);
        m_AWID_i    = id;
        m_AWADDR_i  = addr;
        m_AWBURST_i = 2'd1;
        m_AWLEN_i   = 3'd3;
        m_AWSIZE_i  = 3'd2;
    endtask

    logic        held;
    logic        keep;
    logic        stall;
    logic        exp_ready;
    logic        exp_v;
    logic        exp_slv;
    logic        exp_hs;
    logic [1:0]  exp_onehot;
    aw_payload_t np;

    initial begin
        rv[0] = '{32'h4000_0000, 2'b10, 1'b1};
        rv[1] = '{32'h0000_0000, 2'b01, 1'b0};
        rv[2] = '{32'hC000_0000, 2'b10, 1'b1};
        rv[3] = '{32'h8000_0000, 2'b01, 1'b0};
        rv[4] = '{32'h7FFF_FFFF, 2'b10, 1'b1};
        rv[5] = '{32'hBFFF_FFFC, 2'b01, 1'b0};

        // reset held 3 cycles with master VALID asserted
        aresetn = 1'b0;
        set_aw(5'd7, 32'h4000_0000);
        m_AWVALID_i      = 1'b1;
        sa_AWREADY_i     = 2'b11;
        sa_B_outst_ctn_i = 4'd0;
        dsp_W_full_i     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(); smp();
            chk("rst_valid", 64'(sa_AWVALID_o), 64'd0);
            chk("rst_shift", 64'(dsp_AW_shift_en_o), 64'd0);
        end
        chk("rst_payload", 64'({sa_AWID_o, sa_AWADDR_o}), 64'd0);
        cyc(); aresetn = 1'b1; m_AWVALID_i = 1'b0; smp();
        chk("rst_ready", 64'(m_AWREADY_o), 64'd1);
        chk("rst_valid_after", 64'(sa_AWVALID_o), 64'd0);

        // routing table
        for (int i = 0; i < 6; i++) begin
            cyc(); set_aw(5'(i), rv[i].addr); m_AWVALID_i = 1'b1; smp();
            chk("route_ready", 64'(m_AWREADY_o), 64'd1);
            chk("route_early", 64'(sa_AWVALID_o), 64'd0);
            cyc(); m_AWVALID_i = 1'b0; smp();
            chk("route_valid", 64'(sa_AWVALID_o), 64'(rv[i].exp_valid));
            chk("route_shift", 64'(dsp_AW_shift_en_o), 64'd1);
            chk("route_slv", 64'(dsp_AW_slv_id_o), 64'(rv[i].exp_slv));
            chk("route_addr", 64'(sa_AWADDR_o), 64'(rv[i].addr));
            chk("route_id", 64'(sa_AWID_o), 64'(i));
        end

        // backpressure: three back-to-back AWs into a stalled slave
        cyc(); sa_AWREADY_i = 2'b00; set_aw(5'd1, 32'h0000_1000); m_AWVALID_i = 1'b1; smp();
        chk("bp_rdy1", 64'(m_AWREADY_o), 64'd1);
        cyc(); set_aw(5'd2, 32'h0000_1004); smp();
        chk("bp_rdy2", 64'(m_AWREADY_o), 64'd1);
        chk("bp_valid", 64'(sa_AWVALID_o), 64'h1);
        chk("bp_id1", 64'(sa_AWID_o), 64'd1);
        cyc(); set_aw(5'd3, 32'h0000_1008); smp();
        chk("bp_rdy3", 64'(m_AWREADY_o), 64'd0);
        chk("bp_id_stable", 64'(sa_AWID_o), 64'd1);
        cyc(); smp();
        chk("bp_rdy3_hold", 64'(m_AWREADY_o), 64'd0);
        chk("bp_addr_stable", 64'(sa_AWADDR_o), 64'h1000);
        chk("bp_no_shift", 64'(dsp_AW_shift_en_o), 64'd0);
        cyc(); sa_AWREADY_i = 2'b11; smp();
        chk("bp_push1", 64'({dsp_AW_shift_en_o, sa_AWID_o}), 64'h21);
        cyc(); smp();
        chk("bp_push2", 64'({dsp_AW_shift_en_o, sa_AWID_o}), 64'h22);
        chk("bp_rdy_back", 64'(m_AWREADY_o), 64'd1);
        cyc(); m_AWVALID_i = 1'b0; smp();
        chk("bp_push3", 64'({dsp_AW_shift_en_o, sa_AWID_o}), 64'h23);
        cyc(); smp();
        chk("bp_drained", 64'(dsp_AW_shift_en_o), 64'd0);

        // outstanding limit
        cyc(); sa_B_outst_ctn_i = 4'd8; set_aw(5'd5, 32'h4000_0010); m_AWVALID_i = 1'b1; smp();
        chk("os_ready", 64'(m_AWREADY_o), 64'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(); m_AWVALID_i = 1'b0; smp();
            chk("os_blocked", 64'({sa_AWVALID_o, dsp_AW_shift_en_o}), 64'd0);
        end
        cyc(); sa_B_outst_ctn_i = 4'd7; smp();
        chk("os_release", 64'({sa_AWVALID_o, dsp_AW_shift_en_o, sa_AWID_o}), 64'({2'b10, 1'b1, 5'd5}));
        cyc(); smp();
        chk("os_one_push", 64'({sa_AWVALID_o, dsp_AW_shift_en_o}), 64'd0);
        sa_B_outst_ctn_i = 4'd0;

        // VALID hold across a W-full stall
        cyc(); sa_AWREADY_i = 2'b00; set_aw(5'd9, 32'h0000_2000); m_AWVALID_i = 1'b1; smp();
        cyc(); m_AWVALID_i = 1'b0; smp();
        chk("hold_raise", 64'(sa_AWVALID_o), 64'h1);
        for (int i = 0; i < 2; i++) begin
            cyc(); dsp_W_full_i = 1'b1; smp();
            chk("hold_valid", 64'(sa_AWVALID_o), 64'h1);
            chk("hold_payload", 64'({sa_AWID_o, sa_AWADDR_o}), 64'({5'd9, 32'h0000_2000}));
        end
        cyc(); sa_AWREADY_i = 2'b11; smp();
        chk("hold_hs", 64'({dsp_AW_shift_en_o, sa_AWID_o}), 64'h29);
        cyc(); set_aw(5'd10, 32'h0000_0000); m_AWVALID_i = 1'b1; smp();
        chk("hold_empty", 64'(sa_AWVALID_o), 64'd0);
        cyc(); m_AWVALID_i = 1'b0; smp();
        chk("hold_no_rise", 64'(sa_AWVALID_o), 64'd0);
        cyc(); dsp_W_full_i = 1'b0; smp();
        chk("hold_rise", 64'({sa_AWVALID_o, dsp_AW_shift_en_o, sa_AWID_o}), 64'({2'b01, 1'b1, 5'd10}));
        cyc(); smp();
        chk("hold_done", 64'(dsp_AW_shift_en_o), 64'd0);

        // throughput: 16 AWs alternating slaves
        for (int c = 0; c < 18; c++) begin
            cyc();
            if (c < 16) begin
                set_aw(5'(c), (c % 2 == 1) ? 32'h4000_0100 : 32'h0000_0100);
                m_AWVALID_i = 1'b1;
            end else begin
                m_AWVALID_i = 1'b0;
            end
            smp();
            if (c < 16) chk("tp_ready", 64'(m_AWREADY_o), 64'd1);
            if (c >= 1 && c <= 16) begin
                chk("tp_push", 64'({dsp_AW_shift_en_o, dsp_AW_slv_id_o, sa_AWID_o}),
                    64'({1'b1, 1'((c - 1) % 2), 5'(c - 1)}));
            end else begin
                chk("tp_idle", 64'(dsp_AW_shift_en_o), 64'd0);
            end
        end

        // reset in the middle of buffered traffic
        cyc(); sa_AWREADY_i = 2'b00; set_aw(5'd20, 32'h0); m_AWVALID_i = 1'b1;
        cyc(); set_aw(5'd21, 32'h0);
        cyc(); m_AWVALID_i = 1'b0; smp();
        chk("mr_full", 64'(m_AWREADY_o), 64'd0);
        cyc(); aresetn = 1'b0; sa_AWREADY_i = 2'b11; smp();
        chk("mr_no_shift", 64'({sa_AWVALID_o, dsp_AW_shift_en_o}), 64'd0);
        cyc(); aresetn = 1'b1; smp();
        chk("mr_ready", 64'(m_AWREADY_o), 64'd1);
        chk("mr_empty", 64'({sa_AWVALID_o, dsp_AW_shift_en_o}), 64'd0);

        // randomized traffic against an in-order queue model (capacity 2)
        held = 1'b0;
        keep = 1'b0;
        for (int c = 0; c < 400; c++) begin
            cyc();
            if (!keep) begin
                m_AWVALID_i = ($urandom_range(0, 3) != 0);
                m_AWID_i    = 5'($urandom);
                m_AWADDR_i  = $urandom;
                m_AWBURST_i = 2'($urandom);
                m_AWLEN_i   = 3'($urandom);
                m_AWSIZE_i  = 3'($urandom);
            end
            sa_AWREADY_i     = 2'($urandom);
            sa_B_outst_ctn_i = ($urandom_range(0, 3) == 0) ? 4'd8 : 4'($urandom_range(0, 7));
            dsp_W_full_i     = ($urandom_range(0, 4) == 0);
            smp();
            stall      = (sa_B_outst_ctn_i == 4'd8) || dsp_W_full_i;
            exp_ready  = (mq.size() < 2);
            exp_v      = (mq.size() > 0) && (!stall || held);
            exp_slv    = (mq.size() > 0) ? mq[0].addr[30] : 1'b0;
            exp_onehot = exp_v ? (exp_slv ? 2'b10 : 2'b01) : 2'b00;
            exp_hs     = exp_v && sa_AWREADY_i[exp_slv];
            chk("rnd_ready", 64'(m_AWREADY_o), 64'(exp_ready));
            chk("rnd_valid", 64'(sa_AWVALID_o), 64'(exp_onehot));
            chk("rnd_shift", 64'(dsp_AW_shift_en_o), 64'(exp_hs));
            if (exp_v) begin
                chk("rnd_slv", 64'(dsp_AW_slv_id_o), 64'(exp_slv));
                chk("rnd_payload",
                    64'({sa_AWID_o, sa_AWADDR_o, sa_AWBURST_o, sa_AWLEN_o, sa_AWSIZE_o}),
                    64'(mq[0]));
            end
            if (exp_hs) begin
                void'(mq.pop_front());
                held = 1'b0;
            end else begin
                held = exp_v;
            end
            if (m_AWVALID_i && exp_ready) begin
                np.id    = m_AWID_i;
                np.addr  = m_AWADDR_i;
                np.burst = m_AWBURST_i;
                np.len   = m_AWLEN_i;
                np.size  = m_AWSIZE_i;
                mq.push_back(np);
            end
            keep = m_AWVALID_i && !exp_ready;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
